// File: rtl/bkm_pkg.sv
// Shared encodings for the BKM step sequencer: FSM states, digit codes,
// mode/format codes and the iteration-index width (`LOG2N, default 6).
`ifndef LOG2N
`define LOG2N 6
`endif

package bkm_pkg;
  localparam int LOG2N = `LOG2N;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } seq_state_e;

  localparam logic [1:0] DIG_NEG  = 2'b11;
  localparam logic [1:0] DIG_ZERO = 2'b00;
  localparam logic [1:0] DIG_POS  = 2'b01;
  localparam logic [1:0] DIG_ILL  = 2'b10;

  typedef enum logic {
    MODE_E = 1'b0,
    MODE_L = 1'b1
  } bkm_mode_e;

  typedef enum logic [1:0] {
    FMT_SP = 2'd0,
    FMT_DP = 2'd1,
    FMT_EP = 2'd2,
    FMT_QP = 2'd3
  } bkm_fmt_e;

  function automatic logic dig_illegal(input logic [1:0] d);
    return d == DIG_ILL;
  endfunction
endpackage

// File: rtl/bkm_iter_counter.sv
// BKM iteration index: clears on accept, advances per update and saturates
// at N_ITER-1 so the final index stays visible until the next operand.
module bkm_iter_counter
  import bkm_pkg::*;
#(
  parameter int N_ITER = 64
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             en,
  input  logic             clr,
  input  logic             inc,
  output logic [LOG2N-1:0] n,
  output logic             last
);

  assign last = (n == LOG2N'(N_ITER - 1));

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      n <= '0;
    end else if (en) begin
      if (clr)             n <= '0;
      else if (inc && !last) n <= n + 1'b1;
    end
  end

endmodule

// File: rtl/bkm_step_sequencer.sv
// Sequences the combinational BKM step datapath through N_ITER iterations.
// Options: BKM_SEQ_STEP_REG_EN (two-cycle iterations), RTL_DEBUG (dig_err).
module bkm_step_sequencer
  import bkm_pkg::*;
#(
  parameter int W      = 64,
  parameter int N_ITER = 64
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [1:0]       in_format,
  input  logic [W-1:0]     in_u0,
  input  logic [W-1:0]     in_v0,
  input  logic [1:0]       sel_d_u_n,
  input  logic [1:0]       sel_d_v_n,
  output logic             step_mode,
  output logic [1:0]       step_format,
  output logic [LOG2N-1:0] step_n,
  output logic [1:0]       step_d_u_n,
  output logic [1:0]       step_d_v_n,
  output logic [W-1:0]     step_u_n,
  output logic [W-1:0]     step_v_n,
  input  logic [W-1:0]     step_u_np1,
  input  logic [W-1:0]     step_v_np1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_u,
  output logic [W-1:0]     out_v,
`ifdef RTL_DEBUG
  output logic             dig_err,
`endif
  output logic             busy
);

  seq_state_e   state, state_nxt;
  logic [W-1:0] u_q, v_q;
  bkm_mode_e    mode_q;
  bkm_fmt_e     fmt_q;
  logic         accept, upd, last;

  assign accept = (state == S_IDLE) && in_valid && enable;

`ifdef BKM_SEQ_STEP_REG_EN
  // Phase 0 presents u_n/v_n to a registered step block, phase 1 samples its result.
  logic phase;
  always_ff @(posedge clk or negedge arst) begin
    if (!arst)       phase <= 1'b0;
    else if (enable) phase <= (state == S_RUN) ? ~phase : 1'b0;
  end
  assign upd = (state == S_RUN) && phase;
`else
  assign upd = (state == S_RUN);
`endif

  bkm_iter_counter #(.N_ITER(N_ITER)) u_cnt (
    .clk  (clk),
    .arst (arst),
    .en   (enable),
    .clr  (accept),
    .inc  (upd),
    .n    (step_n),
    .last (last)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid)    state_nxt = S_RUN;
      S_RUN:   if (upd && last) state_nxt = S_DONE;
      S_DONE:  if (out_ready)   state_nxt = S_IDLE;
      default:                  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst)       state <= S_IDLE;
    else if (enable) state <= state_nxt;
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      u_q    <= '0;
      v_q    <= '0;
      mode_q <= MODE_E;
      fmt_q  <= FMT_SP;
    end else if (enable) begin
      if (accept) begin
        u_q    <= in_u0;
        v_q    <= in_v0;
        mode_q <= bkm_mode_e'(in_mode);
        fmt_q  <= bkm_fmt_e'(in_format);
      end else if (upd) begin
        u_q <= step_u_np1;
        v_q <= step_v_np1;
      end
    end
  end

  assign in_ready    = (state == S_IDLE);
  assign out_valid   = (state == S_DONE);
  assign busy        = (state != S_IDLE);
  assign step_mode   = mode_q;
  assign step_format = fmt_q;
  assign step_u_n    = u_q;
  assign step_v_n    = v_q;
  assign out_u       = u_q;
  assign out_v       = v_q;
  assign step_d_u_n  = sel_d_u_n;
  assign step_d_v_n  = sel_d_v_n;

`ifdef RTL_DEBUG
  assign dig_err = upd && enable && (dig_illegal(sel_d_u_n) || dig_illegal(sel_d_v_n));
`endif

endmodule

// File: tb/tb_bkm_step_sequencer.sv
// Self-checking bench for bkm_step_sequencer with a stub step block and an
// arithmetic reference model of the final u/v and iteration timing.
module tb_bkm_step_sequencer;
  import bkm_pkg::*;

  localparam int W = 64;
  localparam int N = 4;
`ifdef BKM_SEQ_STEP_REG_EN
  localparam int CPI = 2;
`else
  localparam int CPI = 1;
`endif

  logic             clk, arst, enable, in_valid, in_ready, in_mode;
  logic [1:0]       in_format, sel_d_u_n, sel_d_v_n;
  logic [W-1:0]     in_u0, in_v0;
  logic             step_mode;
  logic [1:0]       step_format, step_d_u_n, step_d_v_n;
  logic [LOG2N-1:0] step_n;
  logic [W-1:0]     step_u_n, step_v_n, step_u_np1, step_v_np1;
  logic             out_valid, out_ready, busy;
  logic [W-1:0]     out_u, out_v;
`ifdef RTL_DEBUG
  logic             dig_err;
`endif

  int   n_run, n_fail;
  logic stub_sel;

  bkm_step_sequencer #(.W(W), .N_ITER(N)) dut (
    .clk(clk), .arst(arst), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_format(in_format),
    .in_u0(in_u0), .in_v0(in_v0), .sel_d_u_n(sel_d_u_n), .sel_d_v_n(sel_d_v_n),
    .step_mode(step_mode), .step_format(step_format), .step_n(step_n),
    .step_d_u_n(step_d_u_n), .step_d_v_n(step_d_v_n),
    .step_u_n(step_u_n), .step_v_n(step_v_n),
    .step_u_np1(step_u_np1), .step_v_np1(step_v_np1),
    .out_valid(out_valid), .out_ready(out_ready), .out_u(out_u), .out_v(out_v),
`ifdef RTL_DEBUG
    .dig_err(dig_err),
`endif
    .busy(busy)
  );

  // Stub step block: plain increments, or index-weighted increments so that a
  // wrong iteration index shows up in the final value.
  always_comb begin
    if (stub_sel) begin
      step_u_np1 = step_u_n + 64'd1 + (64'(step_n) << 8);
      step_v_np1 = step_v_n + 64'd2 + (64'(step_n) << 16);
    end else begin
      step_u_np1 = step_u_n + 64'd1;
      step_v_np1 = step_v_n + 64'd2;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [W-1:0] model_u(input logic [W-1:0] u0, input logic sel);
    if (sel) return u0 + 64'(N) + 64'(256 * N * (N - 1) / 2);
    return u0 + 64'(N);
  endfunction

  function automatic logic [W-1:0] model_v(input logic [W-1:0] v0, input logic sel);
    if (sel) return v0 + 64'(2 * N) + 64'(65536 * N * (N - 1) / 2);
    return v0 + 64'(2 * N);
  endfunction

  task automatic do_accept(input logic [W-1:0] u0, input logic [W-1:0] v0,
                           input logic mode, input logic [1:0] fmt);
    in_u0 = u0; in_v0 = v0; in_mode = mode; in_format = fmt; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Cycles from the accept edge until out_valid is seen; -1 on timeout.
  task automatic wait_done(output int cyc);
    bit got;
    got = 0; cyc = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (out_valid) got = 1;
    end
    if (!got) cyc = -1;
  endtask

  task automatic consume;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    arst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || step_n !== '0 || step_u_n !== '0 || step_v_n !== '0) begin
      n_fail++;
      $display("FAIL reset_state: out_valid=%b busy=%b n=%0d u=%0h v=%0h, want 0/0/0/0/0",
               out_valid, busy, step_n, step_u_n, step_v_n);
    end
    @(negedge clk); arst = 1'b1;
    @(posedge clk); #1;
    n_run++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b busy=%b, want 1/0", in_ready, busy);
    end
  endtask

  task automatic test_single_op;
    int cyc;
    stub_sel = 1'b0;
    do_accept(64'd10, 64'd20, 1'b0, 2'd0);
    wait_done(cyc);
    n_run++;
    if (cyc != CPI * N) begin
      n_fail++; $display("FAIL single_latency: got %0d cycles, want %0d", cyc, CPI * N);
    end
    n_run++;
    if (out_u !== 64'd14 || out_v !== 64'd28) begin
      n_fail++; $display("FAIL single_result: u=%0d v=%0d, want 14/28", out_u, out_v);
    end
    consume();
    n_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_release: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_random_ops;
    logic [W-1:0] u0, v0;
    logic         mode;
    logic [1:0]   fmt;
    int           c, r, exp_n;
    bit           done;
    stub_sel = 1'b1;
    for (int k = 0; k < 8; k++) begin
      u0 = {$urandom, $urandom}; v0 = {$urandom, $urandom};
      mode = 1'($urandom); fmt = 2'($urandom);
      do_accept(u0, v0, mode, fmt);
      c = 0; done = 0;
      while (!done && c < 100) begin
        r = $urandom_range(0, 2);
        sel_d_u_n = (r == 0) ? 2'b11 : (r == 1) ? 2'b00 : 2'b01;
        r = $urandom_range(0, 2);
        sel_d_v_n = (r == 0) ? 2'b11 : (r == 1) ? 2'b00 : 2'b01;
        #1;
        exp_n = (c / CPI < N - 1) ? c / CPI : N - 1;
        n_run++;
        if (step_d_u_n !== sel_d_u_n || step_d_v_n !== sel_d_v_n ||
            step_mode !== mode || step_format !== fmt || int'(step_n) != exp_n) begin
          n_fail++;
          $display("FAIL rand_step_io: op%0d c=%0d d=%b/%b mode=%b fmt=%0d n=%0d, want d=%b/%b mode=%b fmt=%0d n=%0d",
                   k, c, step_d_u_n, step_d_v_n, step_mode, step_format, step_n,
                   sel_d_u_n, sel_d_v_n, mode, fmt, exp_n);
        end
        @(posedge clk); #1;
        c++;
        done = out_valid;
      end
      n_run++;
      if (!done || c != CPI * N) begin
        n_fail++; $display("FAIL rand_latency: op%0d got %0d cycles, want %0d", k, c, CPI * N);
      end
      n_run++;
      if (out_u !== model_u(u0, 1'b1) || out_v !== model_v(v0, 1'b1)) begin
        n_fail++;
        $display("FAIL rand_result: op%0d u=%0h v=%0h, want %0h/%0h",
                 k, out_u, out_v, model_u(u0, 1'b1), model_v(v0, 1'b1));
      end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      consume();
    end
  endtask

  task automatic test_backpressure;
    int cyc;
    logic [W-1:0] su, sv;
    stub_sel = 1'b0;
    do_accept(64'd1000, 64'd2000, 1'b1, 2'd3);
    wait_done(cyc);
    su = out_u; sv = out_v;
    in_u0 = 64'd77; in_v0 = 64'd88; in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_run++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_u !== su || out_v !== sv) begin
        n_fail++;
        $display("FAIL bp_hold: cyc%0d out_valid=%b in_ready=%b u=%0d v=%0d, want 1/0/%0d/%0d",
                 i, out_valid, in_ready, out_u, out_v, su, sv);
      end
    end
    n_run++;
    if (su !== 64'd1004 || sv !== 64'd2008) begin
      n_fail++; $display("FAIL bp_result: u=%0d v=%0d, want 1004/2008", su, sv);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b, want 0/1/0", out_valid, in_ready, busy);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_run++;
    if (busy !== 1'b1 || step_u_n !== 64'd77 || step_v_n !== 64'd88 || step_n !== '0) begin
      n_fail++;
      $display("FAIL bp_next_accept: busy=%b u=%0d v=%0d n=%0d, want 1/77/88/0", busy, step_u_n, step_v_n, step_n);
    end
    wait_done(cyc);
    n_run++;
    if (cyc != CPI * N || out_u !== 64'd81 || out_v !== 64'd96) begin
      n_fail++; $display("FAIL bp_second_op: cycles=%0d u=%0d v=%0d, want %0d/81/96", cyc, out_u, out_v, CPI * N);
    end
    consume();
  endtask

  task automatic test_enable_stall;
    int cyc;
    stub_sel = 1'b0;
    do_accept(64'd5, 64'd6, 1'b0, 2'd1);
    repeat (CPI) @(posedge clk);
    #1;
    enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_run++;
      if (int'(step_n) != 1 || step_u_n !== 64'd6 || step_v_n !== 64'd8 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold: cyc%0d n=%0d u=%0d v=%0d out_valid=%b, want 1/6/8/0",
                 i, step_n, step_u_n, step_v_n, out_valid);
      end
    end
    enable = 1'b1;
    wait_done(cyc);
    n_run++;
    if (cyc < 0 || CPI + 2 + cyc != CPI * N + 2) begin
      n_fail++; $display("FAIL stall_latency: got %0d cycles, want %0d", CPI + 2 + cyc, CPI * N + 2);
    end
    n_run++;
    if (out_u !== model_u(64'd5, 1'b0) || out_v !== model_v(64'd6, 1'b0)) begin
      n_fail++; $display("FAIL stall_result: u=%0d v=%0d, want 9/14", out_u, out_v);
    end
    // A handshake must not complete while enable is low.
    out_ready = 1'b1; enable = 1'b0;
    @(posedge clk); #1;
    n_run++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL stall_no_handshake: out_valid=%b, want 1", out_valid);
    end
    enable = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    bit seen;
    stub_sel = 1'b0;
    do_accept(64'd100, 64'd200, 1'b1, 2'd2);
    repeat (2 * CPI) @(posedge clk);
    #1;
    n_run++;
    if (int'(step_n) != 2) begin
      n_fail++; $display("FAIL rstmid_pre: n=%0d, want 2", step_n);
    end
    #2 arst = 1'b0;
    #1;
    n_run++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || step_u_n !== '0 || step_v_n !== '0 || step_n !== '0) begin
      n_fail++;
      $display("FAIL rstmid_async: busy=%b out_valid=%b u=%0d v=%0d n=%0d, want all 0",
               busy, out_valid, step_u_n, step_v_n, step_n);
    end
    #1 arst = 1'b1;
    seen = 0;
    for (int i = 0; i < 3 * CPI * N; i++) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen = 1;
    end
    n_run++;
    if (seen) begin
      n_fail++; $display("FAIL rstmid_no_output: activity after release, want none");
    end
  endtask

  initial begin
    n_run = 0; n_fail = 0;
    arst = 1'b0; enable = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_format = 2'd0;
    in_u0 = '0; in_v0 = '0; sel_d_u_n = 2'b00; sel_d_v_n = 2'b00; out_ready = 1'b0;
    stub_sel = 1'b0;
    test_reset();
    test_single_op();
    test_random_ops();
    test_backpressure();
    test_enable_stall();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
